// File: rtl/draw_scheduler_if.sv
// rtl/draw_scheduler_if.sv - Requester and drawer-side bus of the draw scheduler
interface draw_scheduler_if #(
   parameter int NUM_REQ = 3,
   parameter int SW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) ();
   logic [NUM_REQ-1:0]   req;
   logic [4*NUM_REQ-1:0] req_gx;
   logic [4*NUM_REQ-1:0] req_gy;
   logic [NUM_REQ-1:0]   ack;
   logic                 err;
   logic [NUM_REQ-1:0]   drw_en;
   logic [3:0]           grid_x;
   logic [3:0]           grid_y;
   logic [SW-1:0]        sel;
   logic [NUM_REQ-1:0]   drw_done;
   logic                 plot;

   modport master (
      output req, req_gx, req_gy, drw_done,
      input  ack, err, drw_en, grid_x, grid_y, sel, plot
   );

   modport slave (
      input  req, req_gx, req_gy, drw_done,
      output ack, err, drw_en, grid_x, grid_y, sel, plot
   );
endinterface

// File: rtl/draw_scheduler.sv
// rtl/draw_scheduler.sv - Round-robin arbiter sharing the VGA write port among sprite drawers
module draw_scheduler #(
   parameter int NUM_REQ   = 3,
   parameter int START_LAT = 3,
   parameter int DONE_MASK = 2,
   parameter int TIMEOUT   = 1023
) (
   input  logic            clk,
   input  logic            resetn,
   draw_scheduler_if.slave bus,
   output logic            busy
);
   localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAT_M1 = CW'(START_LAT - 1);
   localparam logic [CW-1:0] MASK_C = CW'(DONE_MASK);
   localparam logic [CW-1:0] TO_C   = CW'(TIMEOUT);
   localparam logic [SW-1:0] LAST   = SW'(NUM_REQ - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_GRANT   = 2'd1;
   localparam logic [1:0] S_DRAW    = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;

   logic [1:0]         state;
   logic [SW-1:0]      rr_ptr;
   logic [SW-1:0]      sel_q;
   logic [3:0]         gx_q;
   logic [3:0]         gy_q;
   logic [CW-1:0]      cnt;
   logic [NUM_REQ-1:0] ack_q;
   logic               err_q;
   logic               plot_q;

   logic [SW-1:0]      pick;
   logic [3:0]         pick_gx;
   logic [3:0]         pick_gy;
   logic               found;
   logic [NUM_REQ-1:0] sel_oh;
   logic               done_qual;
   logic               out_of_range;

   // Scan upward from rr_ptr with wrap; first set request wins.
   always_comb begin
      int idx;
      idx     = 0;
      pick    = rr_ptr;
      pick_gx = '0;
      pick_gy = '0;
      found   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_REQ;
         if (!found && bus.req[idx]) begin
            found   = 1'b1;
            pick    = SW'(idx);
            pick_gx = bus.req_gx[4*idx +: 4];
            pick_gy = bus.req_gy[4*idx +: 4];
         end
      end
   end

   assign sel_oh       = NUM_REQ'(1) << sel_q;
   assign out_of_range = (gx_q > 4'd7) || (gy_q > 4'd5);
   // A done level left over from the drawer's previous run is ignored early on.
   assign done_qual    = bus.drw_done[sel_q] && (cnt >= MASK_C);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= S_IDLE;
         rr_ptr <= '0;
         sel_q  <= '0;
         gx_q   <= '0;
         gy_q   <= '0;
         cnt    <= '0;
         ack_q  <= '0;
         err_q  <= 1'b0;
         plot_q <= 1'b0;
      end else begin
         ack_q  <= '0;
         err_q  <= 1'b0;
         plot_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  sel_q <= pick;
                  gx_q  <= pick_gx;
                  gy_q  <= pick_gy;
                  state <= S_GRANT;
               end
            end
            S_GRANT: begin
               cnt <= '0;
               if (out_of_range) begin
                  ack_q <= sel_oh;
                  err_q <= 1'b1;
                  state <= S_RELEASE;
               end else begin
                  state <= S_DRAW;
               end
            end
            S_DRAW: begin
               if (cnt != '1) cnt <= cnt + 1'b1;
               if (done_qual) begin
                  ack_q <= sel_oh;
                  state <= S_RELEASE;
               end else if (cnt == TO_C) begin
                  ack_q <= sel_oh;
                  err_q <= 1'b1;
                  state <= S_RELEASE;
               end else begin
                  // Registered, so plot lines up with the drawer's first valid pixel.
                  plot_q <= (cnt >= LAT_M1);
               end
            end
            default: begin
               rr_ptr <= (sel_q == LAST) ? '0 : sel_q + 1'b1;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ack    = ack_q;
   assign bus.err    = err_q;
   assign bus.drw_en = (state == S_DRAW) ? sel_oh : '0;
   assign bus.grid_x = gx_q;
   assign bus.grid_y = gy_q;
   assign bus.sel    = sel_q;
   assign bus.plot   = plot_q;
   assign busy       = (state != S_IDLE);
endmodule

// File: tb/tb_draw_scheduler.sv
// tb/tb_draw_scheduler.sv - Directed self-checking bench for draw_scheduler
module tb_draw_scheduler;
   localparam int N = 3;

   logic clk = 1'b0;
   logic resetn;
   logic busy;

   always #5 clk = ~clk;

   draw_scheduler_if #(.NUM_REQ(N)) bus ();

   draw_scheduler #(
      .NUM_REQ(N), .START_LAT(3), .DONE_MASK(2), .TIMEOUT(1023)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .bus(bus),
      .busy(busy)
   );

   // Drawer model: pixels on enable cycles 3..402, done level raised on cycle 402,
   // a stale done from the previous run is dropped on enable cycle 2.
   int           ecnt [N];
   bit           hang [N];
   logic [N-1:0] done_r = '0;
   assign bus.drw_done = done_r;

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (bus.drw_en[i]) begin
            if (ecnt[i] == 2) done_r[i] = 1'b0;
            if (ecnt[i] == 402 && !hang[i]) done_r[i] = 1'b1;
            ecnt[i]++;
         end else begin
            ecnt[i] = 0;
         end
      end
   end

   typedef struct {
      logic [N-1:0] ack;
      logic         err;
      int           plot_cnt;
      int           en_cyc;
      logic [N-1:0] en_vec;
      logic [3:0]   gx_en;
      logic [3:0]   gy_en;
      logic [3:0]   gx_ack;
      logic [3:0]   gy_ack;
      int           ack_cyc;
      logic [N-1:0] en_at_ack;
      logic         busy_at_ack;
   } rec_t;

   rec_t         q [$];
   rec_t         mrec;
   int           cyc = 0;
   int           plot_cnt = 0;
   int           en_cyc = -1;
   int           multi_en = 0;
   int           plot_noen = 0;
   logic [N-1:0] en_vec = '0;
   logic         en_prev = 1'b0;
   logic [3:0]   gx_en = '0;
   logic [3:0]   gy_en = '0;

   always @(negedge clk) begin
      cyc++;
      if (!resetn) begin
         plot_cnt = 0;
         en_prev  = 1'b0;
         en_vec   = '0;
         en_cyc   = -1;
      end else begin
         if (bus.plot) plot_cnt++;
         if (bus.plot && bus.drw_en == '0) plot_noen++;
         if ($countones(bus.drw_en) > 1) multi_en++;
         if ((|bus.drw_en) && !en_prev) begin
            en_cyc = cyc;
            en_vec = bus.drw_en;
            gx_en  = bus.grid_x;
            gy_en  = bus.grid_y;
         end
         en_prev = |bus.drw_en;
         if (bus.ack != '0) begin
            mrec.ack         = bus.ack;
            mrec.err         = bus.err;
            mrec.plot_cnt    = plot_cnt;
            mrec.en_cyc      = en_cyc;
            mrec.en_vec      = en_vec;
            mrec.gx_en       = gx_en;
            mrec.gy_en       = gy_en;
            mrec.gx_ack      = bus.grid_x;
            mrec.gy_ack      = bus.grid_y;
            mrec.ack_cyc     = cyc;
            mrec.en_at_ack   = bus.drw_en;
            mrec.busy_at_ack = busy;
            q.push_back(mrec);
            plot_cnt = 0;
            en_vec   = '0;
            en_cyc   = -1;
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Requester side: waits for the next ack, dropping the acked request bits.
   task automatic wait_ack(input int budget, input int poke_at, input bit drop,
                           output rec_t r, output bit ok);
      int c;
      c  = 0;
      ok = 1'b0;
      while (!ok && c < budget) begin
         @(negedge clk); #1;
         if (c == poke_at) begin
            bus.req_gx = ~bus.req_gx;
            bus.req_gy = ~bus.req_gy;
            if (drop) bus.req = '0;
         end
         if (q.size() > 0) begin
            r       = q.pop_front();
            bus.req = bus.req & ~r.ack;
            ok      = 1'b1;
         end
         c++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      resetn = 1'b1;
      q.delete();
   endtask

   typedef struct {
      int         idx;
      logic [3:0] gx;
      logic [3:0] gy;
      bit         exp_err;
      int         exp_plot;
      bit         drop;
   } vec_t;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t         vecs [6];
      rec_t         r;
      bit           ok;
      int           d;
      int           prev_ack;
      int           order [6];
      logic [N-1:0] exp_oh;

      vecs[0] = '{0, 4'd3,  4'd2,  1'b0, 400, 1'b0};
      vecs[1] = '{2, 4'd8,  4'd0,  1'b1, 0,   1'b0};
      vecs[2] = '{1, 4'd7,  4'd5,  1'b0, 400, 1'b0};
      vecs[3] = '{1, 4'd0,  4'd6,  1'b1, 0,   1'b0};
      vecs[4] = '{2, 4'd15, 4'd15, 1'b1, 0,   1'b0};
      vecs[5] = '{0, 4'd0,  4'd0,  1'b0, 400, 1'b1};
      order   = '{0, 1, 2, 0, 1, 2};
      for (int i = 0; i < N; i++) hang[i] = 1'b0;

      resetn     = 1'b0;
      bus.req    = '0;
      bus.req_gx = '0;
      bus.req_gy = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_drw_en", bus.drw_en, 0);
      check("rst_ack",    bus.ack,    0);
      check("rst_err",    bus.err,    0);
      check("rst_plot",   bus.plot,   0);
      check("rst_busy",   busy,       0);
      check("rst_grid_x", bus.grid_x, 0);
      check("rst_grid_y", bus.grid_y, 0);
      check("rst_sel",    bus.sel,    0);
      resetn = 1'b1;

      // Single-request vectors: draws, rejects, late coordinate changes, mid-draw req drop.
      for (int v = 0; v < 6; v++) begin
         exp_oh = N'(1) << vecs[v].idx;
         @(negedge clk); #1;
         bus.req_gx = '1;
         bus.req_gy = '1;
         bus.req_gx[4*vecs[v].idx +: 4] = vecs[v].gx;
         bus.req_gy[4*vecs[v].idx +: 4] = vecs[v].gy;
         bus.req = exp_oh;
         d = cyc;
         wait_ack(2000, 5, vecs[v].drop, r, ok);
         check($sformatf("v%0d_ack_seen", v), ok, 1);
         check($sformatf("v%0d_ack", v), r.ack, exp_oh);
         check($sformatf("v%0d_err", v), r.err, vecs[v].exp_err);
         check($sformatf("v%0d_plot_cycles", v), r.plot_cnt, vecs[v].exp_plot);
         check($sformatf("v%0d_grid_x", v), r.gx_ack, vecs[v].gx);
         check($sformatf("v%0d_grid_y", v), r.gy_ack, vecs[v].gy);
         if (vecs[v].exp_err) begin
            check($sformatf("v%0d_no_enable", v), r.en_vec, 0);
            check($sformatf("v%0d_reject_lat", v), r.ack_cyc - d, 2);
         end else begin
            check($sformatf("v%0d_drw_en", v), r.en_vec, exp_oh);
            check($sformatf("v%0d_en_lat", v), r.en_cyc - d, 2);
            check($sformatf("v%0d_ack_lat", v), r.ack_cyc - r.en_cyc, 403);
            check($sformatf("v%0d_grid_x_at_en", v), r.gx_en, vecs[v].gx);
         end
         repeat (3) @(negedge clk);
         #1;
         check($sformatf("v%0d_single_ack", v), q.size(), 0);
         check($sformatf("v%0d_idle", v), busy, 0);
      end

      // All three requesters held: strict round-robin with immediate re-requests.
      do_reset();
      for (int i = 0; i < N; i++) begin
         bus.req_gx[4*i +: 4] = 4'(i + 1);
         bus.req_gy[4*i +: 4] = 4'(i);
      end
      bus.req  = '1;
      prev_ack = 0;
      for (int k = 0; k < 6; k++) begin
         wait_ack(2000, -1, 1'b0, r, ok);
         check($sformatf("rr%0d_ack_seen", k), ok, 1);
         check($sformatf("rr%0d_ack", k), r.ack, N'(1) << order[k]);
         check($sformatf("rr%0d_drw_en", k), r.en_vec, N'(1) << order[k]);
         check($sformatf("rr%0d_grid_x", k), r.gx_en, order[k] + 1);
         if (k > 0) check($sformatf("rr%0d_regrant_lat", k), r.en_cyc - prev_ack, 3);
         prev_ack = r.ack_cyc;
         if (k < 5) bus.req = '1;
      end

      // Drawer 1 still shows done from its previous run when re-enabled.
      @(negedge clk); #1;
      bus.req_gx[7:4] = 4'd2;
      bus.req_gy[7:4] = 4'd1;
      bus.req = 3'b010;
      wait_ack(2000, -1, 1'b0, r, ok);
      check("stale_ack_seen", ok, 1);
      check("stale_ack", r.ack, 3'b010);
      check("stale_err", r.err, 0);
      check("stale_plot_cycles", r.plot_cnt, 400);
      check("stale_ack_lat", r.ack_cyc - r.en_cyc, 403);

      // Drawer 0 never finishes.
      hang[0] = 1'b1;
      @(negedge clk); #1;
      bus.req_gx[3:0] = 4'd4;
      bus.req_gy[3:0] = 4'd3;
      bus.req = 3'b001;
      wait_ack(1500, -1, 1'b0, r, ok);
      check("to_ack_seen", ok, 1);
      check("to_ack", r.ack, 3'b001);
      check("to_err", r.err, 1);
      check("to_ack_lat", r.ack_cyc - r.en_cyc, 1024);
      check("to_plot_cycles", r.plot_cnt, 1021);
      check("to_en_dropped", r.en_at_ack, 0);
      check("to_busy_at_ack", r.busy_at_ack, 1);
      @(negedge clk); #1;
      check("to_busy_low", busy, 0);
      hang[0] = 1'b0;

      // Reset in the middle of drawer 1's run, requests 0 and 1 held throughout.
      @(negedge clk); #1;
      bus.req_gx = '0;
      bus.req_gy = '0;
      bus.req_gx[3:0] = 4'd1;
      bus.req_gy[3:0] = 4'd1;
      bus.req_gx[7:4] = 4'd2;
      bus.req_gy[7:4] = 4'd2;
      bus.req = 3'b011;
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
         @(negedge clk); #1;
         if (bus.drw_en != '0) ok = 1'b1;
      end
      check("mr_grant_seen", ok, 1);
      check("mr_drw_en", bus.drw_en, 3'b010);
      repeat (100) @(negedge clk);
      #1;
      resetn = 1'b0;
      #1;
      check("mr_drw_en_async", bus.drw_en, 0);
      check("mr_plot_async", bus.plot, 0);
      check("mr_busy_async", busy, 0);
      check("mr_ack_async", bus.ack, 0);
      repeat (2) @(negedge clk);
      #1;
      check("mr_no_ack", q.size(), 0);
      resetn = 1'b1;
      d = cyc;
      wait_ack(2000, -1, 1'b0, r, ok);
      check("mr_ack0_seen", ok, 1);
      check("mr_ack0", r.ack, 3'b001);
      check("mr_en_lat", r.en_cyc - d, 2);
      check("mr_grid_x0", r.gx_en, 1);
      check("mr_plot_cycles", r.plot_cnt, 400);
      wait_ack(2000, -1, 1'b0, r, ok);
      check("mr_ack1_seen", ok, 1);
      check("mr_ack1", r.ack, 3'b010);
      check("mr_grid_x1", r.gx_en, 2);

      repeat (3) @(negedge clk);
      #1;
      check("one_hot_enable", multi_en, 0);
      check("plot_only_when_enabled", plot_noen, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
